// File: rtl/pipereg_wb_multi_if.sv
// Writeback stage bus: per-channel execution-side entries, consumer-side
// registered entries, global flush and the merged redirect.
// Ports (slave = pipeline register, master = surrounding logic / bench):
//   in_*        per-channel entry from the execution blocks (valid/ready)
//   out_*       per-channel registered entry towards PRF/ROB (valid/ready)
//   flush_*     global age-based flush
//   redirect_*  one-cycle oldest-wins redirect
interface pipereg_wb_multi_if #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned PREG_W  = 6,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ROBID_W = 7,
  parameter int unsigned SIDE_W  = 160
);
  localparam int unsigned PC_W = 64;

  logic [NCH-1:0]         in_valid;
  logic [NCH-1:0]         in_ready;
  logic [NCH-1:0]         in_need_to_wb;
  logic [NCH*PREG_W-1:0]  in_prd;
  logic [NCH*DATA_W-1:0]  in_result;
  logic [NCH*ROBID_W-1:0] in_robid;
  logic [NCH-1:0]         in_redirect_valid;
  logic [NCH*PC_W-1:0]    in_redirect_target;
  logic [NCH*SIDE_W-1:0]  in_side;

  logic                   flush_valid;
  logic [ROBID_W-1:0]     flush_robid;

  logic [NCH-1:0]         out_valid;
  logic [NCH-1:0]         out_ready;
  logic [NCH-1:0]         out_need_to_wb;
  logic [NCH*PREG_W-1:0]  out_prd;
  logic [NCH*DATA_W-1:0]  out_result;
  logic [NCH*ROBID_W-1:0] out_robid;
  logic [NCH*SIDE_W-1:0]  out_side;

  logic                   redirect_valid;
  logic [PC_W-1:0]        redirect_target;
  logic [ROBID_W-1:0]     redirect_robid;

  modport master (
    output in_valid, in_need_to_wb, in_prd, in_result, in_robid,
           in_redirect_valid, in_redirect_target, in_side,
           flush_valid, flush_robid, out_ready,
    input  in_ready, out_valid, out_need_to_wb, out_prd, out_result,
           out_robid, out_side, redirect_valid, redirect_target, redirect_robid
  );

  modport slave (
    input  in_valid, in_need_to_wb, in_prd, in_result, in_robid,
           in_redirect_valid, in_redirect_target, in_side,
           flush_valid, flush_robid, out_ready,
    output in_ready, out_valid, out_need_to_wb, out_prd, out_result,
           out_robid, out_side, redirect_valid, redirect_target, redirect_robid
  );
endinterface

// File: rtl/pipereg_wb_multi.sv
// Writeback pipeline register between NCH execution blocks and PRF/ROB.
// Each channel has an output register plus a skid register for full-rate
// valid/ready backpressure, age-based squash on flush, and per-channel
// redirect requests are merged into one registered oldest-wins redirect.
// Ports:
//   clock, reset  clock and synchronous active-high reset
//   wb            pipereg_wb_multi_if.slave (entries in/out, flush, redirect)
module pipereg_wb_multi #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned PREG_W  = 6,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ROBID_W = 7,
  parameter int unsigned SIDE_W  = 160
) (
  input  logic              clock,
  input  logic              reset,
  pipereg_wb_multi_if.slave wb
);
  localparam int unsigned PC_W  = 64;
  localparam int unsigned IDX_W = ROBID_W - 1;

  typedef struct packed {
    logic               need_to_wb;
    logic [PREG_W-1:0]  prd;
    logic [DATA_W-1:0]  result;
    logic [ROBID_W-1:0] robid;
    logic [SIDE_W-1:0]  side;
  } entry_t;

  // a is younger than b; the wrap flag flips the index comparison
  function automatic logic younger(input logic [ROBID_W-1:0] a,
                                   input logic [ROBID_W-1:0] b);
    if (a[ROBID_W-1] == b[ROBID_W-1]) return a[IDX_W-1:0] > b[IDX_W-1:0];
    else                              return a[IDX_W-1:0] < b[IDX_W-1:0];
  endfunction

  entry_t             out_q [NCH];
  entry_t             skid_q[NCH];
  entry_t             out_n [NCH];
  entry_t             skid_n[NCH];
  entry_t             in_e  [NCH];
  logic [NCH-1:0]     out_v_q, skid_v_q, ready_q;
  logic [NCH-1:0]     out_v_n, skid_v_n;
  logic [NCH-1:0]     in_keep, out_live, skid_live, out_free;
  logic               redir_v_q;
  logic [PC_W-1:0]    redir_tgt_q;
  logic [ROBID_W-1:0] redir_rob_q;
  logic               rd_found;
  logic [PC_W-1:0]    rd_target;
  logic [ROBID_W-1:0] rd_robid;

  // Unpack incoming entries; squashed entries still handshake but are not kept
  always_comb begin
    in_keep = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      in_e[i].need_to_wb = wb.in_need_to_wb[i];
      in_e[i].prd        = wb.in_prd[i*PREG_W +: PREG_W];
      in_e[i].result     = wb.in_result[i*DATA_W +: DATA_W];
      in_e[i].robid      = wb.in_robid[i*ROBID_W +: ROBID_W];
      in_e[i].side       = wb.in_side[i*SIDE_W +: SIDE_W];
      in_keep[i] = wb.in_valid[i] & ready_q[i]
                   & ~(wb.flush_valid & younger(in_e[i].robid, wb.flush_robid));
    end
  end

  // Output/skid next state; skid is only ever filled while the output stalls
  always_comb begin
    out_live  = '0;
    skid_live = '0;
    out_free  = '0;
    out_v_n   = out_v_q;
    skid_v_n  = skid_v_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      out_n[i]  = out_q[i];
      skid_n[i] = skid_q[i];
      out_live[i]  = out_v_q[i]
                     & ~(wb.flush_valid & younger(out_q[i].robid, wb.flush_robid));
      skid_live[i] = skid_v_q[i]
                     & ~(wb.flush_valid & younger(skid_q[i].robid, wb.flush_robid));
      out_free[i]  = ~out_live[i] | wb.out_ready[i];
      if (out_free[i]) begin
        skid_v_n[i] = 1'b0;
        if (skid_live[i]) begin
          out_n[i]   = skid_q[i];
          out_v_n[i] = 1'b1;
        end else if (in_keep[i]) begin
          out_n[i]   = in_e[i];
          out_v_n[i] = 1'b1;
        end else begin
          out_v_n[i] = 1'b0;
        end
      end else begin
        out_v_n[i] = 1'b1;
        if (in_keep[i]) begin
          skid_n[i]   = in_e[i];
          skid_v_n[i] = 1'b1;
        end else begin
          skid_v_n[i] = skid_live[i];
        end
      end
    end
  end

  // Oldest surviving redirect; strict compare keeps the lowest channel on ties
  always_comb begin
    rd_found  = 1'b0;
    rd_target = '0;
    rd_robid  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (in_keep[i] && wb.in_redirect_valid[i]
          && (!rd_found || younger(rd_robid, in_e[i].robid))) begin
        rd_found  = 1'b1;
        rd_robid  = in_e[i].robid;
        rd_target = wb.in_redirect_target[i*PC_W +: PC_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        out_q[i]  <= '0;
        skid_q[i] <= '0;
      end
      out_v_q     <= '0;
      skid_v_q    <= '0;
      ready_q     <= '1;
      redir_v_q   <= 1'b0;
      redir_tgt_q <= '0;
      redir_rob_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        out_q[i]  <= out_n[i];
        skid_q[i] <= skid_n[i];
      end
      out_v_q   <= out_v_n;
      skid_v_q  <= skid_v_n;
      ready_q   <= ~skid_v_n;
      redir_v_q <= rd_found;
      if (rd_found) begin
        redir_tgt_q <= rd_target;
        redir_rob_q <= rd_robid;
      end
    end
  end

  // Repack registered entries onto the flat output buses
  logic [NCH-1:0]         out_ntw_c;
  logic [NCH*PREG_W-1:0]  out_prd_c;
  logic [NCH*DATA_W-1:0]  out_result_c;
  logic [NCH*ROBID_W-1:0] out_robid_c;
  logic [NCH*SIDE_W-1:0]  out_side_c;

  always_comb begin
    out_ntw_c    = '0;
    out_prd_c    = '0;
    out_result_c = '0;
    out_robid_c  = '0;
    out_side_c   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      out_ntw_c[i]                        = out_q[i].need_to_wb;
      out_prd_c[i*PREG_W +: PREG_W]       = out_q[i].prd;
      out_result_c[i*DATA_W +: DATA_W]    = out_q[i].result;
      out_robid_c[i*ROBID_W +: ROBID_W]   = out_q[i].robid;
      out_side_c[i*SIDE_W +: SIDE_W]      = out_q[i].side;
    end
  end

  assign wb.in_ready        = ready_q;
  assign wb.out_valid       = out_v_q;
  assign wb.out_need_to_wb  = out_ntw_c;
  assign wb.out_prd         = out_prd_c;
  assign wb.out_result      = out_result_c;
  assign wb.out_robid       = out_robid_c;
  assign wb.out_side        = out_side_c;
  assign wb.redirect_valid  = redir_v_q;
  assign wb.redirect_target = redir_tgt_q;
  assign wb.redirect_robid  = redir_rob_q;
endmodule

// File: tb/tb_pipereg_wb_multi.sv
// Self-checking bench for pipereg_wb_multi: directed handshake/flush/reset
// sequences, a table of redirect-merge vectors and a per-channel scoreboard
// that checks every written-back entry in order.
module tb_pipereg_wb_multi;
  localparam int unsigned NCH = 2, PREG_W = 6, DATA_W = 64, ROBID_W = 7, SIDE_W = 160;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pipereg_wb_multi_if #(.NCH(NCH), .PREG_W(PREG_W), .DATA_W(DATA_W),
                        .ROBID_W(ROBID_W), .SIDE_W(SIDE_W)) bus ();

  pipereg_wb_multi #(.NCH(NCH), .PREG_W(PREG_W), .DATA_W(DATA_W),
                     .ROBID_W(ROBID_W), .SIDE_W(SIDE_W)) dut (
    .clock(clock), .reset(reset), .wb(bus)
  );

  typedef struct {
    logic         ntw;
    logic [5:0]   prd;
    logic [63:0]  result;
    logic [6:0]   robid;
    logic [159:0] side;
  } ent_t;

  typedef struct {
    logic [1:0]  redir;
    logic [6:0]  rob0, rob1;
    logic [63:0] tgt0, tgt1;
    logic        fv;
    logic [6:0]  frob;
    logic        erv;
    logic [63:0] etgt;
    logic [6:0]  erob;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  ent_t sbq [NCH][$];
  ent_t e;
  vec_t vt [8];

  function automatic logic younger(input logic [6:0] a, input logic [6:0] b);
    if (a[6] == b[6]) return a[5:0] > b[5:0];
    return a[5:0] < b[5:0];
  endfunction

  function automatic logic [159:0] mk_side(input logic [6:0] rob, input logic [63:0] res);
    return {res, 25'h0, rob, 64'h5EED_C0DE_0000_0001};
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input int ch, input logic [6:0] rob, input logic [63:0] res,
                     input logic [5:0] prd, input logic ntw, input logic rv,
                     input logic [63:0] tgt);
    bus.in_valid[ch]                   = 1'b1;
    bus.in_robid[ch*7 +: 7]            = rob;
    bus.in_result[ch*64 +: 64]         = res;
    bus.in_prd[ch*6 +: 6]              = prd;
    bus.in_need_to_wb[ch]              = ntw;
    bus.in_redirect_valid[ch]          = rv;
    bus.in_redirect_target[ch*64 +: 64] = tgt;
    bus.in_side[ch*160 +: 160]         = mk_side(rob, res);
  endtask

  task automatic idle_in();
    bus.in_valid          = '0;
    bus.in_redirect_valid = '0;
  endtask

  // Scoreboard: pop on output fire, prune on flush, push on surviving accept
  always @(negedge clock) begin
    if (!reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (bus.out_valid[ch] && bus.out_ready[ch]) begin
          if (sbq[ch].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_ch%0d actual_robid=%h required=no_entry",
                     ch, bus.out_robid[ch*7 +: 7]);
          end else begin
            e = sbq[ch].pop_front();
            chk($sformatf("sb_robid_ch%0d", ch),  160'(bus.out_robid[ch*7 +: 7]),    160'(e.robid));
            chk($sformatf("sb_result_ch%0d", ch), 160'(bus.out_result[ch*64 +: 64]), 160'(e.result));
            chk($sformatf("sb_prd_ch%0d", ch),    160'(bus.out_prd[ch*6 +: 6]),      160'(e.prd));
            chk($sformatf("sb_ntw_ch%0d", ch),    160'(bus.out_need_to_wb[ch]),      160'(e.ntw));
            chk($sformatf("sb_side_ch%0d", ch),   bus.out_side[ch*160 +: 160],       e.side);
          end
        end
        if (bus.flush_valid) begin
          for (int k = int'(sbq[ch].size()) - 1; k >= 0; k--)
            if (younger(sbq[ch][k].robid, bus.flush_robid)) sbq[ch].delete(k);
        end
        if (bus.in_valid[ch] && bus.in_ready[ch]
            && !(bus.flush_valid && younger(bus.in_robid[ch*7 +: 7], bus.flush_robid))) begin
          e.ntw    = bus.in_need_to_wb[ch];
          e.prd    = bus.in_prd[ch*6 +: 6];
          e.result = bus.in_result[ch*64 +: 64];
          e.robid  = bus.in_robid[ch*7 +: 7];
          e.side   = mk_side(e.robid, e.result);
          sbq[ch].push_back(e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        redir  rob0   rob1   tgt0                  tgt1                  fv    frob   erv   etgt                  erob
    vt[0] = '{2'b11, 7'h42, 7'h3E, 64'h0000_0000_8000_1000, 64'h0000_0000_8000_2000, 1'b0, 7'h00, 1'b1, 64'h0000_0000_8000_2000, 7'h3E};
    vt[1] = '{2'b11, 7'h01, 7'h7F, 64'h0000_0000_9000_0100, 64'h0000_0000_9000_0200, 1'b0, 7'h00, 1'b1, 64'h0000_0000_9000_0200, 7'h7F};
    vt[2] = '{2'b01, 7'h20, 7'h10, 64'h0000_0000_0000_A000, 64'h0000_0000_0000_A111, 1'b0, 7'h00, 1'b1, 64'h0000_0000_0000_A000, 7'h20};
    vt[3] = '{2'b11, 7'h30, 7'h30, 64'h0000_0000_0000_B000, 64'h0000_0000_0000_C000, 1'b0, 7'h00, 1'b1, 64'h0000_0000_0000_B000, 7'h30};
    vt[4] = '{2'b00, 7'h31, 7'h32, 64'h0000_0000_0000_1111, 64'h0000_0000_0000_2222, 1'b0, 7'h00, 1'b0, 64'h0000_0000_0000_B000, 7'h30};
    vt[5] = '{2'b11, 7'h55, 7'h60, 64'h0000_0000_0000_D000, 64'h0000_0000_0000_D100, 1'b1, 7'h50, 1'b0, 64'h0000_0000_0000_B000, 7'h30};
    vt[6] = '{2'b11, 7'h55, 7'h50, 64'h0000_0000_0000_D000, 64'h0000_0000_0000_E000, 1'b1, 7'h50, 1'b1, 64'h0000_0000_0000_E000, 7'h50};
    vt[7] = '{2'b11, 7'h3A, 7'h45, 64'h0000_0000_0000_F000, 64'h0000_0000_0000_F100, 1'b0, 7'h00, 1'b1, 64'h0000_0000_0000_F000, 7'h3A};

    bus.in_valid = '0; bus.in_need_to_wb = '0; bus.in_prd = '0; bus.in_result = '0;
    bus.in_robid = '0; bus.in_redirect_valid = '0; bus.in_redirect_target = '0;
    bus.in_side = '0; bus.flush_valid = 1'b0; bus.flush_robid = '0; bus.out_ready = '0;

    // Reset for two cycles
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    chk("rst_out_valid", 160'(bus.out_valid), 160'(2'b00));
    chk("rst_redir_valid", 160'(bus.redirect_valid), 160'(1'b0));
    chk("rst_out_result", 160'(bus.out_result), 160'(0));
    chk("rst_redir_target", 160'(bus.redirect_target), 160'(0));
    step();
    chk("rst_in_ready", 160'(bus.in_ready), 160'(2'b11));

    // Single entry, one-cycle latency, valid for exactly one cycle
    bus.out_ready = 2'b11;
    put(0, 7'h03, 64'hDEAD_BEEF, 6'd5, 1'b1, 1'b0, 64'h0);
    step();
    idle_in();
    chk("t2_out_valid", 160'(bus.out_valid[0]), 160'(1'b1));
    chk("t2_result", 160'(bus.out_result[63:0]), 160'(64'hDEAD_BEEF));
    chk("t2_prd", 160'(bus.out_prd[5:0]), 160'(6'd5));
    chk("t2_robid", 160'(bus.out_robid[6:0]), 160'(7'h03));
    step();
    chk("t2_out_valid_drop", 160'(bus.out_valid[0]), 160'(1'b0));

    // Backpressure on ch1: output + skid, FIFO drain
    bus.out_ready = 2'b01;
    put(1, 7'd10, 64'h1000_000A, 6'd10, 1'b1, 1'b0, 64'h0);
    step();
    chk("t3_rdy_after1", 160'(bus.in_ready[1]), 160'(1'b1));
    chk("t3_out_rob10", 160'(bus.out_robid[13:7]), 160'(7'd10));
    put(1, 7'd11, 64'h1000_000B, 6'd11, 1'b1, 1'b0, 64'h0);
    step();
    chk("t3_rdy_after2", 160'(bus.in_ready[1]), 160'(1'b0));
    put(1, 7'd12, 64'h1000_000C, 6'd12, 1'b0, 1'b0, 64'h0);
    step();
    chk("t3_hold_rob", 160'(bus.out_robid[13:7]), 160'(7'd10));
    chk("t3_hold_res", 160'(bus.out_result[127:64]), 160'(64'h1000_000A));
    chk("t3_hold_rdy", 160'(bus.in_ready[1]), 160'(1'b0));
    bus.out_ready = 2'b11;
    step();
    chk("t3_out_rob11", 160'(bus.out_robid[13:7]), 160'(7'd11));
    chk("t3_rdy_back", 160'(bus.in_ready[1]), 160'(1'b1));
    step();
    idle_in();
    chk("t3_out_rob12", 160'(bus.out_robid[13:7]), 160'(7'd12));
    step();
    chk("t3_drained", 160'(bus.out_valid[1]), 160'(1'b0));

    // Flush on held output/skid: equal id stays, younger skid removed
    bus.out_ready = 2'b10;
    put(0, 7'h05, 64'h5555, 6'd1, 1'b1, 1'b0, 64'h0);
    step();
    put(0, 7'h06, 64'h6666, 6'd2, 1'b1, 1'b0, 64'h0);
    step();
    idle_in();
    chk("t4_pre_rob", 160'(bus.out_robid[6:0]), 160'(7'h05));
    chk("t4_pre_rdy", 160'(bus.in_ready[0]), 160'(1'b0));
    bus.flush_valid = 1'b1; bus.flush_robid = 7'h05;
    step();
    bus.flush_valid = 1'b0;
    chk("t4_keep_valid", 160'(bus.out_valid[0]), 160'(1'b1));
    chk("t4_keep_rob", 160'(bus.out_robid[6:0]), 160'(7'h05));
    chk("t4_rdy_free", 160'(bus.in_ready[0]), 160'(1'b1));
    bus.out_ready = 2'b11;
    step();
    chk("t4_no_extra", 160'(bus.out_valid[0]), 160'(1'b0));
    step();
    chk("t4_no_extra2", 160'(bus.out_valid[0]), 160'(1'b0));

    // Flush kills output but skid survives and moves up
    bus.out_ready = 2'b10;
    put(0, 7'h10, 64'h1010, 6'd3, 1'b1, 1'b0, 64'h0);
    step();
    put(0, 7'h08, 64'h0808, 6'd4, 1'b0, 1'b0, 64'h0);
    step();
    idle_in();
    bus.flush_valid = 1'b1; bus.flush_robid = 7'h09;
    step();
    bus.flush_valid = 1'b0;
    chk("t4b_valid", 160'(bus.out_valid[0]), 160'(1'b1));
    chk("t4b_rob", 160'(bus.out_robid[6:0]), 160'(7'h08));
    chk("t4b_rdy", 160'(bus.in_ready[0]), 160'(1'b1));
    bus.out_ready = 2'b11;
    step();
    chk("t4b_drained", 160'(bus.out_valid[0]), 160'(1'b0));

    // Redirect-merge vector table
    for (int r = 0; r < 8; r++) begin
      put(0, vt[r].rob0, {32'h0000_00A0, 25'h0, vt[r].rob0}, 6'(r), logic'(r % 2), vt[r].redir[0], vt[r].tgt0);
      put(1, vt[r].rob1, {32'h0000_00B0, 25'h0, vt[r].rob1}, 6'(r + 8), 1'b1, vt[r].redir[1], vt[r].tgt1);
      bus.flush_valid = vt[r].fv;
      bus.flush_robid = vt[r].frob;
      step();
      idle_in();
      bus.flush_valid = 1'b0;
      chk($sformatf("vec%0d_rv", r), 160'(bus.redirect_valid), 160'(vt[r].erv));
      chk($sformatf("vec%0d_tgt", r), 160'(bus.redirect_target), 160'(vt[r].etgt));
      chk($sformatf("vec%0d_rob", r), 160'(bus.redirect_robid), 160'(vt[r].erob));
      step();
      chk($sformatf("vec%0d_pulse", r), 160'(bus.redirect_valid), 160'(1'b0));
    end

    // Reset mid-operation discards held entries
    bus.out_ready = 2'b00;
    put(0, 7'h22, 64'h2222, 6'd7, 1'b1, 1'b0, 64'h0);
    step();
    idle_in();
    step();
    reset = 1'b1;
    step();
    sbq[0].delete();
    sbq[1].delete();
    reset = 1'b0;
    chk("rst2_out_valid", 160'(bus.out_valid), 160'(2'b00));
    chk("rst2_in_ready", 160'(bus.in_ready), 160'(2'b11));
    bus.out_ready = 2'b11;
    step();
    chk("rst2_no_wb", 160'(bus.out_valid), 160'(2'b00));

    // Final drain
    step(); step();
    chk("end_q0_empty", 160'(sbq[0].size()), 160'(0));
    chk("end_q1_empty", 160'(sbq[1].size()), 160'(0));
    chk("end_out_valid", 160'(bus.out_valid), 160'(2'b00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
